jar_sram_ctrl: RTL

- Host-side controller for the nibble-serial 8-byte SRAM macro.
- Arbitrates NREQ requesters round-robin and converts each parallel byte read or write into the macro's pin sequence on its 8-bit io_in: addr_data[7:4], oe[2], we[1], sclk[0].
- Captures read data from the macro's io_out and returns it with a one-cycle response pulse.
- Sits between the on-chip requesters and the macro.

---
 rtl/jar_sram_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jar_sram_ctrl.sv
// Host-side controller for the nibble-serial 8-byte SRAM macro.
// Round-robin arbitrates requesters and sequences byte reads/writes onto the macro pins.
module jar_sram_ctrl #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy,
  input  logic [DW-1:0]      sram_io_out,
  output logic [DW-1:0]      sram_io_in
);

  localparam int unsigned NW = DW / 2;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WLO_S, S_WLO_E, S_WHI_S, S_WHI_E,
    S_COM_S, S_COM_E, S_RD_S, S_RD_E, S_RD_CAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DW-1:0]     r_rdata;
  logic              r_busy;
  logic [DW-1:0]     r_io;

  logic [AW-1:0]     w_addr_arr  [NREQ];
  logic [DW-1:0]     w_wdata_arr [NREQ];
  logic [NREQ-1:0]   w_grant;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_idx;
  logic              w_found;
  logic              w_win_we;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_wdata;
  logic              w_ld;
  logic [NREQ-1:0]   w_rsp_nxt;
  logic [AW-1:0]     w_src_addr;
  logic [DW-1:0]     w_src_wdata;
  logic [NW-1:0]     w_nib;
  logic              w_oe;
  logic              w_we_pin;
  logic              w_sclk;
  logic [DW-1:0]     w_io_nxt;

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*AW +: AW];
    assign w_wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_grant     = '0;
    w_win       = '0;
    w_idx       = '0;
    w_found     = 1'b0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = PW'((int'(r_ptr) + k) % int'(NREQ));
      if (!w_found && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_win          = w_idx;
        w_win_we       = req_we[w_idx];
        w_win_addr     = w_addr_arr[w_idx];
        w_win_wdata    = w_wdata_arr[w_idx];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;

  // Next state, then the pin word for that state so sram_io_in is registered in step.
  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_rsp_nxt   = '0;
    w_src_addr  = r_addr;
    w_src_wdata = r_wdata;
    w_nib       = '0;
    w_oe        = 1'b0;
    w_we_pin    = 1'b0;
    w_sclk      = 1'b0;
    w_io_nxt    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ld        = 1'b1;
          w_src_addr  = w_win_addr;
          w_src_wdata = w_win_wdata;
          w_state_nxt = w_win_we ? S_WLO_S : S_RD_S;
        end
      end
      S_WLO_S: w_state_nxt = S_WLO_E;
      S_WLO_E: w_state_nxt = S_WHI_S;
      S_WHI_S: w_state_nxt = S_WHI_E;
      S_WHI_E: w_state_nxt = S_COM_S;
      S_COM_S: w_state_nxt = S_COM_E;
      S_COM_E: begin
        w_state_nxt = S_IDLE;
        w_rsp_nxt   = NREQ'(1) << r_owner;
      end
      S_RD_S:  w_state_nxt = S_RD_E;
      S_RD_E:  w_state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        w_state_nxt = S_IDLE;
        w_rsp_nxt   = NREQ'(1) << r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_WLO_S, S_WLO_E: begin
        w_nib    = w_src_wdata[NW-1:0];
        w_we_pin = 1'b1;
      end
      S_WHI_S, S_WHI_E: begin
        w_nib    = w_src_wdata[DW-1:NW];
        w_we_pin = 1'b1;
      end
      S_COM_S, S_COM_E: begin
        w_nib    = NW'(w_src_addr);
        w_oe     = 1'b1;
        w_we_pin = 1'b1;
      end
      S_RD_S, S_RD_E, S_RD_CAP: begin
        w_nib = NW'(w_src_addr);
        w_oe  = 1'b1;
      end
      default: w_nib = '0;
    endcase
    w_sclk = (w_state_nxt == S_WLO_E) || (w_state_nxt == S_WHI_E) ||
             (w_state_nxt == S_COM_E) || (w_state_nxt == S_RD_E) ||
             (w_state_nxt == S_RD_CAP);
    if (w_state_nxt != S_IDLE) begin
      w_io_nxt = DW'({w_nib, 1'b0, w_oe, w_we_pin, w_sclk});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_io        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_io        <= w_io_nxt;
      if (w_ld) begin
        r_we    <= w_win_we;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
        r_owner <= w_win;
        r_ptr   <= PW'((int'(w_win) + 1) % int'(NREQ));
      end
      if (r_state == S_RD_CAP) begin
        r_rdata <= sram_io_out;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign busy       = r_busy;
  assign sram_io_in = r_io;

endmodule
